// File: rtl/mel_log_if.sv
// Streaming handshake between the mel filterbank, the log2 converter and the DCT.
// The master drives energies in and consumes log values; the slave is mel_log.
interface mel_log_if #(
  parameter int ENERGY_WIDTH = 32,
  parameter int OUT_WIDTH    = 8,
  parameter int NF_LOG2      = 6
);
  logic                        in_valid_i;
  logic [ENERGY_WIDTH-1:0]     energy_i;
  logic                        in_ready_o;
  logic                        out_valid_o;
  logic signed [OUT_WIDTH-1:0] log_o;
  logic [NF_LOG2-1:0]          ptr_o;
  logic                        start_o;

  modport master (
    output in_valid_i, energy_i,
    input  in_ready_o, out_valid_o, log_o, ptr_o, start_o
  );

  modport slave (
    input  in_valid_i, energy_i,
    output in_ready_o, out_valid_o, log_o, ptr_o, start_o
  );
endinterface

// File: rtl/mel_log.sv
// Fixed-point log2 of mel filter energies by leading-zero normalisation, one bit per cycle.
// Define MEL_LOG_ROUND_EN to round the fraction to nearest (saturating) instead of truncating.
module mel_log #(
  parameter int NUM_FILTERS  = 40,
  parameter int ENERGY_WIDTH = 32,
  parameter int FRAC_BITS    = 3,
  parameter int OUT_WIDTH    = $clog2(ENERGY_WIDTH) + FRAC_BITS,
  parameter int NF_LOG2      = $clog2(NUM_FILTERS)
) (
  input  logic     clk,
  input  logic     rst,
  mel_log_if.slave bus
);

  localparam int                     CNT_W     = $clog2(ENERGY_WIDTH);
  localparam logic [OUT_WIDTH-1:0]   MSB_TOP   = OUT_WIDTH'(ENERGY_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0]   BIAS      = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [NF_LOG2-1:0]     LAST_FILT = NF_LOG2'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {IDLE, NORM, EMIT} state_e;

  state_e                  state_q, state_d;
  logic [ENERGY_WIDTH-1:0] x_q;
  logic [CNT_W-1:0]        shift_q;
  logic                    zero_q;
  logic                    hold_q;
  logic [NF_LOG2-1:0]      filt_q;
  logic                    valid_q;
  logic                    start_q;
  logic [OUT_WIDTH-1:0]    log_q, log_d;
  logic [NF_LOG2-1:0]      ptr_q;

  logic in_ready;
  logic accept;
  logic emit;
  logic x_msb;

  assign x_msb = x_q[ENERGY_WIDTH-1];

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses <= so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  // NOTE: state_d defaults to state_q first so every path assigns it; no latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid_i) state_d = (bus.energy_i == '0) ? EMIT : NORM;
      NORM: if (x_msb)          state_d = EMIT;
      EMIT: if (!hold_q)        state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- state outputs
  always_comb begin
    in_ready = (state_q == IDLE);
    accept   = in_ready && bus.in_valid_i;
    emit     = (state_q == EMIT) && !hold_q;
  end

  // ---------------------------------------------------------------- normaliser
  // NOTE: these datapath flops are left unreset; acceptance always loads them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q     <= bus.energy_i;
      shift_q <= '0;
      zero_q  <= (bus.energy_i == '0);
      hold_q  <= (bus.energy_i == '0);
    end else begin
      if (state_q == NORM && !x_msb) begin
        x_q     <= x_q << 1;
        shift_q <= shift_q + CNT_W'(1);
      end
      // A zero energy spends one pad cycle in EMIT so it lines up with an
      // already-normalised energy (both strobe two cycles after acceptance).
      if (state_q == EMIT) hold_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- log code
  logic [OUT_WIDTH-1:0] msb_pos;
  logic [FRAC_BITS-1:0] frac;
  logic [OUT_WIDTH-1:0] code_trunc;
  logic [OUT_WIDTH-1:0] code;
`ifdef MEL_LOG_ROUND_EN
  logic [OUT_WIDTH:0]   code_sum;
`endif

  always_comb begin
    msb_pos    = MSB_TOP - OUT_WIDTH'(shift_q);
    frac       = x_q[ENERGY_WIDTH-2 -: FRAC_BITS];
    code_trunc = (msb_pos << FRAC_BITS) + OUT_WIDTH'(frac);
`ifdef MEL_LOG_ROUND_EN
    // Round half up on the first dropped bit; a carry out of the code saturates.
    code_sum = {1'b0, code_trunc} + (OUT_WIDTH+1)'(x_q[ENERGY_WIDTH-2-FRAC_BITS]);
    code     = code_sum[OUT_WIDTH] ? '1 : code_sum[OUT_WIDTH-1:0];
`else
    code     = code_trunc;
`endif
    if (zero_q) code = '0;
    log_d = code - BIAS;
  end

  // ---------------------------------------------------------------- output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      log_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= emit;
      // The frame is complete once the last filter's strobe has gone out.
      start_q <= valid_q && (ptr_q == LAST_FILT);
      if (emit) begin
        log_q  <= log_d;
        ptr_q  <= filt_q;
        filt_q <= (filt_q == LAST_FILT) ? '0 : filt_q + NF_LOG2'(1);
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = valid_q;
  assign bus.log_o       = $signed(log_q);
  assign bus.ptr_o       = ptr_q;
  assign bus.start_o     = start_q;

endmodule
